mem_arb_512x8b: RTL and testbench
=================================

Name: mem_arb_512x8b

Overview:
Two-requester arbiter that shares one single-port mem_512x8b data RAM between the ice51 core (port A) and a secondary master (port B, e.g. a UART DMA or debug loader).
- Grants at most one access per cycle using round-robin priority.
- Supports locked bursts bounded by a hold counter.
- Returns read data with valid strobes that track the RAM's 1-cycle synchronous read latency.
- Sits between the masters and the RAM instance at top level.

Parameters:
ADDR_W, 9, RAM address width (512 entries)
DATA_W, 8, RAM data width
MAX_LOCK, 16, maximum consecutive cycles one port may hold a lock while the other port is requesting (range 1..255)

Ports:
i_clk  input  1  clock
i_nrst  input  1  asynchronous active-low reset
i_a_req  input  1  port A access request
i_a_lock  input  1  port A asks to keep ownership after this access
i_a_we  input  1  port A write enable (0 = read)
i_a_addr  input  ADDR_W  port A address
i_a_wdata  input  DATA_W  port A write data
o_a_gnt  output  1  port A access accepted this cycle
o_a_rvalid  output  1  port A read data valid
o_a_rdata  output  DATA_W  port A read data
i_b_req, i_b_lock, i_b_we, i_b_addr, i_b_wdata  input  as port A  port B request side
o_b_gnt, o_b_rvalid, o_b_rdata  output  as port A  port B response side
o_mem_we  output  1  RAM write enable
o_mem_addr  output  ADDR_W  RAM address
o_mem_wdata  output  DATA_W  RAM write data
i_mem_rdata  input  DATA_W  RAM read data (valid 1 cycle after a read address)

Behaviour:
- Reset (async, i_nrst=0): state=IDLE, rr_last=B (A wins the first tie), hold_cnt=0, rvalid pipe cleared. o_*_gnt, o_*_rvalid and o_mem_we are 0; o_mem_addr, o_mem_wdata and o_*_rdata are 0.
- State machine: IDLE, OWN_A, OWN_B (registered).
  - IDLE: grant the sole requester. If both request, grant the port != rr_last. No requester -> no grant.
  - OWN_x: port x has absolute priority. Another port is granted only if x deasserts req.
- Grant is combinational in the request cycle: o_x_gnt = winner & i_x_req. A request is accepted only when gnt=1. The requester holds req/we/addr/wdata stable until gnt.
- RAM drive is a combinational mux of the granted port:
  - o_mem_we = gnt & we.
  - With no grant, o_mem_we=0 and addr/wdata hold the last granted values (registered shadow).
- On every grant: rr_last <= granted port. Next state is OWN_x if i_x_lock=1, else IDLE.
- Read return:
  - Granted read sets rv_a / rv_b one cycle later.
  - o_x_rvalid = rv_x; o_x_rdata = i_mem_rdata when rv_x, else holds its previous registered value.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid on consecutive cycles.
- Hold counter:
  - In OWN_x, hold_cnt increments each cycle the other port requests, saturating at MAX_LOCK.
  - When hold_cnt==MAX_LOCK, the lock is ignored for one arbitration: the other port wins the next contended cycle, then hold_cnt clears.
  - hold_cnt clears on any transition out of OWN_x.
- Lock on a non-granted cycle has no effect. Lock asserted with req=0 in OWN_x -> return to IDLE.
- Simultaneous requests, both locked: round-robin picks the winner; the loser waits.
- Reset mid-burst: ownership is dropped and any pending rvalid is discarded (not delivered after reset).

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: port A always wins contention in IDLE and rr_last is not used. Locks and the hold counter still apply, so B is guaranteed progress after MAX_LOCK cycles of A lock only.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with both req=1 -> after i_nrst rises, first cycle o_a_gnt=1, o_b_gnt=0. Both gnt=0 while i_nrst=0.
- A writes 0xA5 @0x1F3, then B reads 0x1F3 -> o_mem_we=1 addr=0x1F3 on cycle 0. B gnt on cycle 1. o_b_rvalid=1, o_b_rdata=0xA5 on cycle 2. o_a_rvalid stays 0.
- Both request reads continuously, no lock -> grants alternate A,B,A,B. Each rvalid follows its grant by exactly 1 cycle.
- A locked (lock=1), B requesting, MAX_LOCK=4 -> A granted 4 cycles, B granted cycle 5, then A resumes.
- A locked burst of 3 reads with B idle -> 3 consecutive A grants, state OWN_A, hold_cnt stays 0. A drops req -> IDLE; next B req granted immediately.
- With MEM_ARB_FIXED_PRIO_EN, both requesting unlocked -> A granted every cycle, B never granted until A deasserts req.

Source files
------------

// File: rtl/mem_arb_512x8b.sv
// mem_arb_512x8b: two-port round-robin arbiter in front of a single-port 512x8
// data RAM (ice51 core on port A, secondary master on port B).
//
// Ownership:
//   - A granted access with lock=1 keeps the port in OWN_A / OWN_B.
//   - The hold counter bounds how long a lock can starve the other port.
//
// Read return:
//   - Read data comes back with rvalid strobes that follow the RAM's
//     one-cycle read latency.
//
// Build option:
//   - Define MEM_ARB_FIXED_PRIO_EN to make port A win every idle-state tie.
//   - In that build round-robin is not used, but locks and the hold counter
//     still apply.
module mem_arb_512x8b #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 8,
   parameter int MAX_LOCK = 16
) (
   input  logic              i_clk,
   input  logic              i_nrst,
   input  logic              i_a_req,
   input  logic              i_a_lock,
   input  logic              i_a_we,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   output logic              o_a_gnt,
   output logic              o_a_rvalid,
   output logic [DATA_W-1:0] o_a_rdata,
   input  logic              i_b_req,
   input  logic              i_b_lock,
   input  logic              i_b_we,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_wdata,
   output logic              o_b_gnt,
   output logic              o_b_rvalid,
   output logic [DATA_W-1:0] o_b_rdata,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} arbState_t;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

   arbState_t         r_state;
   arbState_t         w_nextState;
   logic [CNT_W-1:0]  r_holdCnt;
   logic [CNT_W-1:0]  w_holdNext;
   logic [CNT_W-1:0]  w_holdBase;
   logic              w_holdFull;
   logic              w_gntA;
   logic              w_gntB;
   logic              r_rvA;
   logic              r_rvB;
   logic [ADDR_W-1:0] r_addrShadow;
   logic [DATA_W-1:0] r_wdataShadow;
   logic [DATA_W-1:0] r_aRdata;
   logic [DATA_W-1:0] r_bRdata;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
   logic              r_rrLast;
`endif

   assign w_holdFull = (r_holdCnt == LOCK_LIMIT);

   // Pick this cycle's winner.
   // Grants are forced low while reset is asserted.
   // A saturated hold counter hands one contended cycle to the waiting port.
   always_comb begin
      w_gntA = 1'b0;
      w_gntB = 1'b0;
      if (i_nrst) begin
         case (r_state)
            OWN_A: begin
               if (i_a_req && !(w_holdFull && i_b_req))
                  w_gntA = 1'b1;
               else if (i_b_req)
                  w_gntB = 1'b1;
            end
            OWN_B: begin
               if (i_b_req && !(w_holdFull && i_a_req))
                  w_gntB = 1'b1;
               else if (i_a_req)
                  w_gntA = 1'b1;
            end
            default: begin
               if (i_a_req && i_b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                  w_gntA = 1'b1;
`else
                  w_gntA = r_rrLast;
                  w_gntB = !r_rrLast;
`endif
               end else begin
                  w_gntA = i_a_req;
                  w_gntB = i_b_req;
               end
            end
         endcase
      end
   end

   // Decide the next ownership state and hold count from the grant.
   // A lock opens or extends an ownership window; anything else drops back
   // to IDLE. The count restarts whenever a port newly takes ownership.
   always_comb begin
      w_nextState = IDLE;
      w_holdNext  = '0;
      w_holdBase  = '0;
      if (w_gntA && i_a_lock) begin
         w_nextState = OWN_A;
         w_holdBase  = (r_state == OWN_A) ? r_holdCnt : '0;
         w_holdNext  = (i_b_req && (w_holdBase != LOCK_LIMIT)) ? w_holdBase + CNT_W'(1) : w_holdBase;
      end else if (w_gntB && i_b_lock) begin
         w_nextState = OWN_B;
         w_holdBase  = (r_state == OWN_B) ? r_holdCnt : '0;
         w_holdNext  = (i_a_req && (w_holdBase != LOCK_LIMIT)) ? w_holdBase + CNT_W'(1) : w_holdBase;
      end
   end

   // Ownership state and hold counter registers.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state   <= IDLE;
         r_holdCnt <= '0;
      end else begin
         r_state   <= w_nextState;
         r_holdCnt <= w_holdNext;
      end
   end

`ifdef MEM_ARB_FIXED_PRIO_EN
`else
   // Remember the last granted port so the next idle-state tie goes to the other port.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst)
         r_rrLast <= 1'b1;
      else if (w_gntA)
         r_rrLast <= 1'b0;
      else if (w_gntB)
         r_rrLast <= 1'b1;
   end
`endif

   // Shadow the last granted address and write data so the RAM bus stays put on idle cycles.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_addrShadow  <= '0;
         r_wdataShadow <= '0;
      end else if (w_gntA) begin
         r_addrShadow  <= i_a_addr;
         r_wdataShadow <= i_a_wdata;
      end else if (w_gntB) begin
         r_addrShadow  <= i_b_addr;
         r_wdataShadow <= i_b_wdata;
      end
   end

   // Track which port owns the read data returning next cycle.
   // Reset clears this pipe so a read in flight is never delivered.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_rvA <= 1'b0;
         r_rvB <= 1'b0;
      end else begin
         r_rvA <= w_gntA && !i_a_we;
         r_rvB <= w_gntB && !i_b_we;
      end
   end

   // Capture returned read data per port so each rdata output holds between reads.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_aRdata <= '0;
         r_bRdata <= '0;
      end else begin
         if (r_rvA)
            r_aRdata <= i_mem_rdata;
         if (r_rvB)
            r_bRdata <= i_mem_rdata;
      end
   end

   assign o_a_gnt     = w_gntA;
   assign o_b_gnt     = w_gntB;
   assign o_mem_we    = (w_gntA && i_a_we) || (w_gntB && i_b_we);
   assign o_mem_addr  = w_gntA ? i_a_addr  : (w_gntB ? i_b_addr  : r_addrShadow);
   assign o_mem_wdata = w_gntA ? i_a_wdata : (w_gntB ? i_b_wdata : r_wdataShadow);
   assign o_a_rvalid  = r_rvA;
   assign o_b_rvalid  = r_rvB;
   assign o_a_rdata   = r_rvA ? i_mem_rdata : r_aRdata;
   assign o_b_rdata   = r_rvB ? i_mem_rdata : r_bRdata;

endmodule

// File: tb/tb_mem_arb_512x8b.sv
// tb_mem_arb_512x8b: table-driven check of the two-port RAM arbiter.
// A behavioural synchronous-read RAM sits behind the arbiter. MAX_LOCK is
// shrunk to 4 so lock starvation limits are reached quickly.
module tb_mem_arb_512x8b;

   typedef struct {
      logic       aReq;
      logic       aLock;
      logic       aWe;
      logic [8:0] aAddr;
      logic [7:0] aWdata;
      logic       bReq;
      logic       bLock;
      logic       bWe;
      logic [8:0] bAddr;
      logic [7:0] bWdata;
      logic       expAGnt;
      logic       expBGnt;
      logic       expMemWe;
      logic [8:0] expMemAddr;
      logic       expARv;
      logic [7:0] expARd;
      logic       expBRv;
      logic [7:0] expBRd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstN;
   logic       aReq, aLock, aWe, bReq, bLock, bWe;
   logic [8:0] aAddr, bAddr;
   logic [7:0] aWdata, bWdata;
   logic       aGnt, aRvalid, bGnt, bRvalid, memWe;
   logic [7:0] aRdata, bRdata, memWdata;
   logic [8:0] memAddr;
   logic [7:0] memRdata = 8'h00;
   logic [7:0] ram [512];

   int nAsserts = 0;
   int nFails   = 0;
   vec_t vecs [30];

   mem_arb_512x8b #(.ADDR_W(9), .DATA_W(8), .MAX_LOCK(4)) dut (
      .i_clk(clk), .i_nrst(rstN),
      .i_a_req(aReq), .i_a_lock(aLock), .i_a_we(aWe), .i_a_addr(aAddr), .i_a_wdata(aWdata),
      .o_a_gnt(aGnt), .o_a_rvalid(aRvalid), .o_a_rdata(aRdata),
      .i_b_req(bReq), .i_b_lock(bLock), .i_b_we(bWe), .i_b_addr(bAddr), .i_b_wdata(bWdata),
      .o_b_gnt(bGnt), .o_b_rvalid(bRvalid), .o_b_rdata(bRdata),
      .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
      .i_mem_rdata(memRdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with read-first, one-cycle read latency.
   always @(posedge clk) begin
      if (memWe)
         ram[memAddr] <= memWdata;
      memRdata <= ram[memAddr];
   end

   function automatic vec_t mk(
      input logic aR, input logic aL, input logic aW, input logic [8:0] aA, input logic [7:0] aD,
      input logic bR, input logic bL, input logic bW, input logic [8:0] bA, input logic [7:0] bD,
      input logic gA, input logic gB, input logic mW, input logic [8:0] mA,
      input logic aV, input logic [7:0] aQ, input logic bV, input logic [7:0] bQ);
      vec_t v;
      v.aReq = aR; v.aLock = aL; v.aWe = aW; v.aAddr = aA; v.aWdata = aD;
      v.bReq = bR; v.bLock = bL; v.bWe = bW; v.bAddr = bA; v.bWdata = bD;
      v.expAGnt = gA; v.expBGnt = gB; v.expMemWe = mW; v.expMemAddr = mA;
      v.expARv = aV; v.expARd = aQ; v.expBRv = bV; v.expBRd = bQ;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nAsserts++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      aReq = v.aReq; aLock = v.aLock; aWe = v.aWe; aAddr = v.aAddr; aWdata = v.aWdata;
      bReq = v.bReq; bLock = v.bLock; bWe = v.bWe; bAddr = v.bAddr; bWdata = v.bWdata;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      chk($sformatf("row%0d a_gnt", idx),    32'(aGnt),    32'(v.expAGnt));
      chk($sformatf("row%0d b_gnt", idx),    32'(bGnt),    32'(v.expBGnt));
      chk($sformatf("row%0d mem_we", idx),   32'(memWe),   32'(v.expMemWe));
      chk($sformatf("row%0d mem_addr", idx), 32'(memAddr), 32'(v.expMemAddr));
      chk($sformatf("row%0d a_rvalid", idx), 32'(aRvalid), 32'(v.expARv));
      chk($sformatf("row%0d a_rdata", idx),  32'(aRdata),  32'(v.expARd));
      chk($sformatf("row%0d b_rvalid", idx), 32'(bRvalid), 32'(v.expBRv));
      chk($sformatf("row%0d b_rdata", idx),  32'(bRdata),  32'(v.expBRd));
   endtask

   initial begin
      for (int i = 0; i < 512; i++)
         ram[i] = 8'h00;

      //            aReq aLk aWe aAddr   aWd    bReq bLk bWe bAddr   bWd    gA gB mWe addr    aRv aRd    bRv bRd
      vecs[0]  = mk(1, 0, 1, 9'h1F3, 8'hA5, 1, 0, 0, 9'h1F3, 8'h00, 1, 0, 1, 9'h1F3, 0, 8'h00, 0, 8'h00);
      vecs[1]  = mk(0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h1F3, 8'h00, 0, 1, 0, 9'h1F3, 0, 8'h00, 0, 8'h00);
      vecs[2]  = mk(0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1F3, 0, 8'h00, 1, 8'hA5);
      vecs[3]  = mk(1, 0, 1, 9'h010, 8'h11, 0, 0, 0, 9'h000, 8'h00, 1, 0, 1, 9'h010, 0, 8'h00, 0, 8'hA5);
      vecs[4]  = mk(0, 0, 0, 9'h000, 8'h00, 1, 0, 1, 9'h020, 8'h22, 0, 1, 1, 9'h020, 0, 8'h00, 0, 8'hA5);
      vecs[5]  = mk(1, 0, 0, 9'h010, 8'h00, 1, 0, 0, 9'h020, 8'h00, 1, 0, 0, 9'h010, 0, 8'h00, 0, 8'hA5);
      vecs[6]  = mk(1, 0, 0, 9'h020, 8'h00, 1, 0, 0, 9'h020, 8'h00, 0, 1, 0, 9'h020, 1, 8'h11, 0, 8'hA5);
      vecs[7]  = mk(1, 0, 0, 9'h020, 8'h00, 1, 0, 0, 9'h010, 8'h00, 1, 0, 0, 9'h020, 0, 8'h11, 1, 8'h22);
      vecs[8]  = mk(0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h010, 8'h00, 0, 1, 0, 9'h010, 1, 8'h22, 0, 8'h22);
      vecs[9]  = mk(0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h010, 0, 8'h22, 1, 8'h11);
      vecs[10] = mk(1, 1, 0, 9'h010, 8'h00, 1, 0, 0, 9'h020, 8'h00, 1, 0, 0, 9'h010, 0, 8'h22, 0, 8'h11);
      vecs[11] = mk(1, 1, 0, 9'h020, 8'h00, 1, 0, 0, 9'h020, 8'h00, 1, 0, 0, 9'h020, 1, 8'h11, 0, 8'h11);
      vecs[12] = mk(1, 1, 0, 9'h010, 8'h00, 1, 0, 0, 9'h020, 8'h00, 1, 0, 0, 9'h010, 1, 8'h22, 0, 8'h11);
      vecs[13] = mk(1, 1, 0, 9'h020, 8'h00, 1, 0, 0, 9'h020, 8'h00, 1, 0, 0, 9'h020, 1, 8'h11, 0, 8'h11);
      vecs[14] = mk(1, 1, 0, 9'h010, 8'h00, 1, 0, 0, 9'h020, 8'h00, 0, 1, 0, 9'h020, 1, 8'h22, 0, 8'h11);
      vecs[15] = mk(1, 1, 0, 9'h010, 8'h00, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h010, 0, 8'h22, 1, 8'h22);
      vecs[16] = mk(0, 1, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h010, 1, 8'h11, 0, 8'h22);
      vecs[17] = mk(0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h010, 8'h00, 0, 1, 0, 9'h010, 0, 8'h11, 0, 8'h22);
      vecs[18] = mk(0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h010, 0, 8'h11, 1, 8'h11);
      vecs[19] = mk(1, 1, 0, 9'h020, 8'h00, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h020, 0, 8'h11, 0, 8'h11);
      vecs[20] = mk(1, 1, 0, 9'h010, 8'h00, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h010, 1, 8'h22, 0, 8'h11);
      vecs[21] = mk(1, 1, 0, 9'h020, 8'h00, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h020, 1, 8'h11, 0, 8'h11);
      vecs[22] = mk(0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h020, 8'h00, 0, 1, 0, 9'h020, 1, 8'h22, 0, 8'h11);
      vecs[23] = mk(0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h020, 0, 8'h22, 1, 8'h22);
      vecs[24] = mk(1, 1, 0, 9'h010, 8'h00, 1, 1, 0, 9'h020, 8'h00, 1, 0, 0, 9'h010, 0, 8'h22, 0, 8'h22);
      vecs[25] = mk(1, 0, 0, 9'h020, 8'h00, 1, 1, 0, 9'h020, 8'h00, 1, 0, 0, 9'h020, 1, 8'h11, 0, 8'h22);
      vecs[26] = mk(0, 0, 0, 9'h000, 8'h00, 1, 1, 0, 9'h020, 8'h00, 0, 1, 0, 9'h020, 1, 8'h22, 0, 8'h22);
      vecs[27] = mk(1, 0, 0, 9'h030, 8'h00, 1, 0, 1, 9'h030, 8'h33, 0, 1, 1, 9'h030, 0, 8'h22, 1, 8'h22);
      vecs[28] = mk(1, 0, 0, 9'h030, 8'h00, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h030, 0, 8'h22, 0, 8'h22);
      vecs[29] = mk(0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h030, 1, 8'h33, 0, 8'h22);

      // Hold reset with both ports requesting: nothing may be granted.
      rstN = 1'b0;
      applyStimulus(vecs[0]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset a_gnt",    32'(aGnt),    32'd0);
      chk("reset b_gnt",    32'(bGnt),    32'd0);
      chk("reset mem_we",   32'(memWe),   32'd0);
      chk("reset mem_addr", 32'(memAddr), 32'd0);
      chk("reset a_rvalid", 32'(aRvalid), 32'd0);
      chk("reset b_rvalid", 32'(bRvalid), 32'd0);

`ifdef MEM_ARB_FIXED_PRIO_EN
      // Port A always wins contention while it keeps requesting.
      @(posedge clk); #1;
      rstN = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         applyStimulus(mk(1, 0, 0, 9'(c), 8'h00, 1, 0, 0, 9'h020, 8'h00, 0, 0, 0, 9'h000, 0, 8'h00, 0, 8'h00));
         @(negedge clk);
         chk($sformatf("fixed c%0d a_gnt", c), 32'(aGnt), 32'd1);
         chk($sformatf("fixed c%0d b_gnt", c), 32'(bGnt), 32'd0);
      end
      @(posedge clk); #1;
      applyStimulus(mk(0, 0, 0, 9'h000, 8'h00, 1, 0, 0, 9'h020, 8'h00, 0, 0, 0, 9'h000, 0, 8'h00, 0, 8'h00));
      @(negedge clk);
      chk("fixed release a_gnt", 32'(aGnt), 32'd0);
      chk("fixed release b_gnt", 32'(bGnt), 32'd1);
`else
      // Directed cycle-by-cycle table; reset releases together with row 0.
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (i == 0)
            rstN = 1'b1;
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(i, vecs[i]);
      end

      // Reset mid-burst: B owns the RAM with a read in flight.
      @(posedge clk); #1;
      applyStimulus(mk(0, 0, 0, 9'h000, 8'h00, 1, 1, 0, 9'h020, 8'h00, 0, 0, 0, 9'h000, 0, 8'h00, 0, 8'h00));
      @(negedge clk);
      chk("burst b_gnt", 32'(bGnt), 32'd1);
      chk("burst a_gnt", 32'(aGnt), 32'd0);
      @(posedge clk); #1;
      rstN = 1'b0;
      applyStimulus(mk(1, 0, 0, 9'h010, 8'h00, 1, 1, 0, 9'h020, 8'h00, 0, 0, 0, 9'h000, 0, 8'h00, 0, 8'h00));
      @(negedge clk);
      chk("midrst b_rvalid", 32'(bRvalid), 32'd0);
      chk("midrst b_rdata",  32'(bRdata),  32'd0);
      chk("midrst a_rdata",  32'(aRdata),  32'd0);
      chk("midrst a_gnt",    32'(aGnt),    32'd0);
      chk("midrst b_gnt",    32'(bGnt),    32'd0);
      chk("midrst mem_we",   32'(memWe),   32'd0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      chk("postrst a_gnt",    32'(aGnt),    32'd1);
      chk("postrst b_gnt",    32'(bGnt),    32'd0);
      chk("postrst b_rvalid", 32'(bRvalid), 32'd0);
      @(posedge clk); #1;
      applyStimulus(mk(0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h000, 0, 8'h00, 0, 8'h00));
      @(negedge clk);
      chk("postrst a_rvalid", 32'(aRvalid), 32'd1);
      chk("postrst a_rdata",  32'(aRdata),  32'h11);
      chk("postrst b_rvalid2", 32'(bRvalid), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
